// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: generates every radix-2 butterfly operand pair and its
// twiddle index, stage by stage, for an in-place FFT over SAMPLES points.
// Optional macro FFT_SEQ_STAGE_BARRIER_EN: adds a pipe_idle input and a
// BARRIER state that waits for the butterfly pipeline to drain after each stage.
module fft_stage_sequencer #(
  parameter int SAMPLES = 16,
  parameter int WIDTH   = 3,
  parameter int LOG2N   = $clog2(SAMPLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pair_valid,
  input  logic             pair_ready,
`ifdef FFT_SEQ_STAGE_BARRIER_EN
  input  logic             pipe_idle,
`endif
  output logic [LOG2N-1:0] idx_a,
  output logic [LOG2N-1:0] idx_b,
  output logic [LOG2N-2:0] tw_idx,
  output logic [LOG2N-1:0] stage,
  output logic             last_pair
);

  // WIDTH only sizes the external datapath; it is checked here for sanity.
  if (SAMPLES < 4 || SAMPLES > 1024 || (SAMPLES & (SAMPLES - 1)) != 0 ||
      LOG2N != $clog2(SAMPLES) || WIDTH < 1) begin : g_param_check
    $error("fft_stage_sequencer: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
`ifdef FFT_SEQ_STAGE_BARRIER_EN
    , ST_BARRIER
`endif
  } state_t;

  state_t           state_reg, state_next;
  logic [LOG2N-1:0] s_reg, s_next;
  logic [LOG2N-2:0] g_reg, g_next;
  logic [LOG2N-2:0] j_reg, j_next;
  logic [LOG2N-1:0] idx_a_reg, idx_a_next;
  logic [LOG2N-1:0] idx_b_reg, idx_b_next;
  logic [LOG2N-2:0] tw_reg, tw_next;
  logic             load;
  logic [LOG2N-1:0] span, grp_cnt, span_next, tw_shift;
  logic             j_last, g_last, s_last;

  // Position within the current stage: end of butterfly run, group, stage.
  always_comb begin
    span    = LOG2N'(1) << s_reg;
    grp_cnt = LOG2N'(SAMPLES / 2) >> s_reg;
    j_last  = ({1'b0, j_reg} == span - 1'b1);
    g_last  = ({1'b0, g_reg} == grp_cnt - 1'b1);
    s_last  = (s_reg == LOG2N'(LOG2N - 1));
  end

  // Next state and counter advance; counters move only on start or transfer.
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    g_next     = g_reg;
    j_next     = j_reg;
    load       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_RUN;
          s_next     = '0;
          g_next     = '0;
          j_next     = '0;
          load       = 1'b1;
        end
      end
      ST_RUN: begin
        if (pair_ready) begin
          load = 1'b1;
          if (!j_last) begin
            j_next = j_reg + 1'b1;
          end else if (!g_last) begin
            j_next = '0;
            g_next = g_reg + 1'b1;
          end else begin
            j_next = '0;
            g_next = '0;
            // After the final stage the counters fold back to zero, which
            // also tells the barrier that the transform is complete.
            s_next = s_last ? '0 : s_reg + 1'b1;
`ifdef FFT_SEQ_STAGE_BARRIER_EN
            state_next = ST_BARRIER;
`else
            if (s_last) state_next = ST_DONE;
`endif
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
`ifdef FFT_SEQ_STAGE_BARRIER_EN
      ST_BARRIER: begin
        if (pipe_idle) state_next = (s_reg == '0) ? ST_DONE : ST_RUN;
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // Addresses and twiddle index for the pair the counters will point at next.
  always_comb begin
    span_next  = LOG2N'(1) << s_next;
    tw_shift   = LOG2N'(LOG2N - 1) - s_next;
    idx_a_next = ((LOG2N'(g_next) << 1) << s_next) + LOG2N'(j_next);
    idx_b_next = idx_a_next + span_next;
    tw_next    = j_next << tw_shift;
  end

  // State, counters and registered pair outputs; held while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      s_reg     <= '0;
      g_reg     <= '0;
      j_reg     <= '0;
      idx_a_reg <= '0;
      idx_b_reg <= '0;
      tw_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        s_reg     <= s_next;
        g_reg     <= g_next;
        j_reg     <= j_next;
        idx_a_reg <= idx_a_next;
        idx_b_reg <= idx_b_next;
        tw_reg    <= tw_next;
      end
    end
  end

`ifdef FFT_SEQ_STAGE_BARRIER_EN
  assign busy = (state_reg == ST_RUN) || (state_reg == ST_BARRIER);
`else
  assign busy = (state_reg == ST_RUN);
`endif
  assign done       = (state_reg == ST_DONE);
  assign pair_valid = (state_reg == ST_RUN);
  assign last_pair  = (state_reg == ST_RUN) && s_last && g_last && j_last;
  assign idx_a      = idx_a_reg;
  assign idx_b      = idx_b_reg;
  assign tw_idx     = tw_reg;
  assign stage      = s_reg;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: scoreboard bench for a 16-point and a 4-point
// sequencer sharing one clock; expected pairs come from hand-written tables.
module tb_fft_stage_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start16 = 1'b0, ready16 = 1'b0;
  logic       busy16, done16, pv16, last16;
  logic [3:0] a16, b16, stage16;
  logic [2:0] tw16;

  logic       start4 = 1'b0, ready4 = 1'b0;
  logic       busy4, done4, pv4, last4;
  logic [1:0] a4, b4, stage4;
  logic [0:0] tw4;

`ifdef FFT_SEQ_STAGE_BARRIER_EN
  logic idle16 = 1'b1, idle4 = 1'b1;
`endif

  int n_vec = 0, n_err = 0;
  int rdy_mode = 0, cyc = 0;
  logic [39:0] q16[$], q4[$];

  // {idx_a, idx_b, tw} per pair; stage = index / 8, last pair is entry 31
  logic [11:0] tab16 [32] = '{
    12'h010, 12'h230, 12'h450, 12'h670, 12'h890, 12'hAB0, 12'hCD0, 12'hEF0,
    12'h020, 12'h134, 12'h460, 12'h574, 12'h8A0, 12'h9B4, 12'hCE0, 12'hDF4,
    12'h040, 12'h152, 12'h264, 12'h376, 12'h8C0, 12'h9D2, 12'hAE4, 12'hBF6,
    12'h080, 12'h191, 12'h2A2, 12'h3B3, 12'h4C4, 12'h5D5, 12'h6E6, 12'h7F7};
  logic [11:0] tab4 [4] = '{12'h010, 12'h230, 12'h020, 12'h131};

  always #5 clk = ~clk;

  fft_stage_sequencer #(.SAMPLES(16), .WIDTH(3)) u16 (
    .clk(clk), .rst(rst), .start(start16), .busy(busy16), .done(done16),
    .pair_valid(pv16), .pair_ready(ready16),
`ifdef FFT_SEQ_STAGE_BARRIER_EN
    .pipe_idle(idle16),
`endif
    .idx_a(a16), .idx_b(b16), .tw_idx(tw16), .stage(stage16), .last_pair(last16));

  fft_stage_sequencer #(.SAMPLES(4), .WIDTH(3)) u4 (
    .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4),
    .pair_valid(pv4), .pair_ready(ready4),
`ifdef FFT_SEQ_STAGE_BARRIER_EN
    .pipe_idle(idle4),
`endif
    .idx_a(a4), .idx_b(b4), .tw_idx(tw4), .stage(stage4), .last_pair(last4));

  function automatic logic [39:0] mk(input logic [7:0] a, input logic [7:0] b,
                                     input logic [7:0] tw, input logic [7:0] s,
                                     input logic last);
    return {7'b0, last, s, tw, a, b};
  endfunction

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push16();
    for (int i = 0; i < 32; i++)
      q16.push_back(mk(8'(tab16[i][11:8]), 8'(tab16[i][7:4]), 8'(tab16[i][3:0]),
                       8'(i / 8), (i == 31)));
  endtask

  task automatic push4();
    for (int i = 0; i < 4; i++)
      q4.push_back(mk(8'(tab4[i][11:8]), 8'(tab4[i][7:4]), 8'(tab4[i][3:0]),
                      8'(i / 2), (i == 3)));
  endtask

  task automatic pulse(input bit which);
    @(negedge clk);
    if (which) start4 = 1'b1; else start16 = 1'b1;
    @(negedge clk);
    start4  = 1'b0;
    start16 = 1'b0;
    if (which) chk("first_valid4", 48'({busy4, pv4}), 48'(2'b11));
    else       chk("first_valid16", 48'({busy16, pv16}), 48'(2'b11));
  endtask

  task automatic wait_done(input bit which, input int bound);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < bound && !seen; c++) begin
      @(negedge clk);
      seen = which ? done4 : done16;
    end
    if (which) chk("done4_seen", 48'(seen), 48'(1));
    else       chk("done16_seen", 48'(seen), 48'(1));
  endtask

  // Ready driver: constant or a repeating two-on/two-off backpressure pattern
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      ready16 = (rdy_mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
      ready4  = 1'b1;
    end
  end

  // Monitor for the 16-point instance
  logic [39:0] held16;
  bit stall16 = 1'b0, expd16 = 1'b0;
  always @(negedge clk) begin
    logic [39:0] obs, exp;
    obs = mk(8'(a16), 8'(b16), 8'(tw16), 8'(stage16), last16);
    if (rst) begin
      stall16 = 1'b0;
      expd16  = 1'b0;
    end else begin
`ifdef FFT_SEQ_STAGE_BARRIER_EN
      if (done16) begin
        chk("done16_pulse", 48'({expd16, busy16, pv16}), 48'(3'b100));
        expd16 = 1'b0;
      end
`else
      if (expd16) chk("done16_pulse", 48'({done16, busy16, pv16}), 48'(3'b100));
      else        chk("done16_idle", 48'(done16), 48'(0));
      expd16 = 1'b0;
`endif
      if (stall16) chk("hold16", 48'({pv16, obs}), 48'({1'b1, held16}));
      stall16 = pv16 && !ready16;
      held16  = obs;
      if (pv16 && ready16) begin
        $display("pair16 stage=%0d a=%0d b=%0d tw=%0d last=%0d", stage16, a16, b16, tw16, last16);
        exp = (q16.size() != 0) ? q16.pop_front() : '1;
        chk("pair16", 48'(obs), 48'(exp));
        if (last16) expd16 = 1'b1;
      end
    end
  end

  // Monitor for the 4-point instance
  logic [39:0] held4;
  bit stall4 = 1'b0, expd4 = 1'b0;
  always @(negedge clk) begin
    logic [39:0] obs, exp;
    obs = mk(8'(a4), 8'(b4), 8'(tw4), 8'(stage4), last4);
    if (rst) begin
      stall4 = 1'b0;
      expd4  = 1'b0;
    end else begin
`ifdef FFT_SEQ_STAGE_BARRIER_EN
      if (done4) begin
        chk("done4_pulse", 48'({expd4, busy4, pv4}), 48'(3'b100));
        expd4 = 1'b0;
      end
`else
      if (expd4) chk("done4_pulse", 48'({done4, busy4, pv4}), 48'(3'b100));
      else       chk("done4_idle", 48'(done4), 48'(0));
      expd4 = 1'b0;
`endif
      if (stall4) chk("hold4", 48'({pv4, obs}), 48'({1'b1, held4}));
      stall4 = pv4 && !ready4;
      held4  = obs;
      if (pv4 && ready4) begin
        $display("pair4 stage=%0d a=%0d b=%0d tw=%0d last=%0d", stage4, a4, b4, tw4, last4);
        exp = (q4.size() != 0) ? q4.pop_front() : '1;
        chk("pair4", 48'(obs), 48'(exp));
        if (last4) expd4 = 1'b1;
      end
    end
  end

  // Directed stimulus
  initial begin
    bit found;
    #3;
    chk("reset16", 48'({busy16, done16, pv16, last16, a16, b16, tw16, stage16}), 48'(0));
    chk("reset4", 48'({busy4, done4, pv4, last4, a4, b4, tw4, stage4}), 48'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // nominal transform, ready always high
    push16();
    pulse(1'b0);
    wait_done(1'b0, 200);
    chk("count16_nominal", 48'(q16.size()), 48'(0));

    // backpressure
    rdy_mode = 1;
    push16();
    pulse(1'b0);
    wait_done(1'b0, 400);
    chk("count16_backpressure", 48'(q16.size()), 48'(0));
    rdy_mode = 0;

    // start held through a whole transform
    push16();
    push16();
    @(negedge clk);
    start16 = 1'b1;
    wait_done(1'b0, 300);
    @(negedge clk);
    chk("gap_busy16", 48'(busy16), 48'(0));
    @(negedge clk);
    chk("restart_busy16", 48'(busy16), 48'(1));
    start16 = 1'b0;
    wait_done(1'b0, 300);
    chk("count16_held_start", 48'(q16.size()), 48'(0));

    // asynchronous reset during stage 2
    push16();
    pulse(1'b0);
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      found = pv16 && (stage16 == 4'd2);
    end
    chk("reach_stage2", 48'(found), 48'(1));
    #2 rst = 1'b1;
    #1 chk("async_rst16", 48'({busy16, done16, pv16, last16, a16, b16, tw16, stage16}), 48'(0));
    q16.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("no_done_after_rst", 48'(done16), 48'(0));
    end
    push16();
    pulse(1'b0);
    wait_done(1'b0, 200);
    chk("count16_after_rst", 48'(q16.size()), 48'(0));

    // four-point transform
    push4();
    pulse(1'b1);
    wait_done(1'b1, 50);
    chk("count4", 48'(q4.size()), 48'(0));

`ifdef FFT_SEQ_STAGE_BARRIER_EN
    // stage barrier with pipe_idle held low for five cycles per stage
    idle16 = 1'b0;
    push16();
    pulse(1'b0);
    for (int s = 0; s < 4; s++) begin
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
        @(negedge clk);
        found = busy16 && !pv16;
      end
      chk("bar_enter", 48'(found), 48'(1));
      for (int k = 0; k < 5; k++) begin
        if (k > 0) @(negedge clk);
        chk("bar_hold", 48'({pv16, done16, busy16}), 48'(3'b001));
      end
      idle16 = 1'b1;
      @(posedge clk);
      #1 idle16 = 1'b0;
      @(negedge clk);
      if (s < 3) chk("bar_resume", 48'({pv16, stage16}), 48'({1'b1, 4'(s + 1)}));
      else       chk("bar_done", 48'({done16, pv16}), 48'(2'b10));
    end
    idle16 = 1'b1;
    chk("count16_barrier", 48'(q16.size()), 48'(0));
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog so the bench always ends
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Sequences a radix-2 in-place FFT over SAMPLES points held in a sample RAM.
- For each stage s = 0..log2(SAMPLES)-1, issues every butterfly operand pair (idx_a, idx_b) plus its twiddle index to the butterfly datapath, over a valid/ready handshake.
- Pairing per stage: for group g in 0..(SAMPLES/2 >> s)-1 and j in 0..(1<<s)-1, with base = g*(2<<s): idx_a = base+j, idx_b = base+j+(1<<s).
- Sits between the sample reorder stage and the butterfly/twiddle ROM; one start produces one complete transform.

Parameters:
- SAMPLES, 16, FFT points; power of two, 4..1024.
- WIDTH, 3, sample width; passed through for datapath sizing only, unused internally.
- LOG2N, $clog2(SAMPLES), derived: index width and stage count.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin transform; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last pair is accepted
- pair_valid  out  1  idx_a/idx_b/tw_idx/stage are valid
- pair_ready  in  1  datapath accepts the pair (transfer = valid & ready)
- idx_a  out  LOG2N  upper butterfly operand address
- idx_b  out  LOG2N  lower butterfly operand address
- tw_idx  out  LOG2N-1  twiddle ROM index = j << (LOG2N-1-s)
- stage  out  LOG2N  current stage number s
- last_pair  out  1  high with the final pair of the final stage

Behaviour:
- Reset (async, immediate): state=IDLE; busy=0, done=0, pair_valid=0, last_pair=0, idx_a=0, idx_b=0, tw_idx=0, stage=0; internal counters g, j and s cleared.
- Reset mid-transform aborts the transform. No done pulse is produced; the next start begins again from stage 0.
- State IDLE:
  - start=1 -> RUN; counters s=0, g=0, j=0.
  - The first pair is presented with pair_valid=1 in the cycle after start is sampled.
  - busy rises in that same cycle.
- State RUN:
  - pair_valid=1 continuously.
  - Outputs are registered and held stable while pair_valid & !pair_ready.
  - On each transfer, advance the counters:
    - j+1 if j < (1<<s)-1;
    - else j=0 and g+1, if g < (SAMPLES/2>>s)-1;
    - else j=0, g=0, s+1.
  - The next pair appears the following cycle, so the block sustains 1 pair per cycle under constant ready.
- Transfer of the pair with last_pair=1 -> DONE.
- State DONE: lasts one cycle. done=1, pair_valid=0, busy=0, then -> IDLE.
- start is ignored outside IDLE, and also in the DONE cycle.
- Total transfers per transform = (SAMPLES/2)*LOG2N.
- All address arithmetic is unsigned and LOG2N bits wide. idx_b never exceeds SAMPLES-1; no wrap occurs.
- pair_ready asserted while pair_valid=0 has no effect.

Optional Feature:
- Macro: FFT_SEQ_STAGE_BARRIER_EN.
- When defined:
  - Adds input port pipe_idle (1 bit, high when the butterfly pipeline has written back all results).
  - After the last pair of each non-final stage transfers, enter state BARRIER with pair_valid=0 and busy=1.
  - Leave BARRIER for RUN at stage s+1 on the first cycle pipe_idle=1; the first pair of the new stage is valid the cycle after.
  - After the final stage, go to DONE only once pipe_idle=1, waiting in BARRIER if it is low.
- When undefined:
  - No pipe_idle port and no BARRIER state.
  - Stages issue back-to-back with no bubble, as described under Behaviour.

Test Plan:
- SAMPLES=16, start pulse, pair_ready=1 always:
  - exactly 32 transfers;
  - stage 0 pairs (0,1),(2,3)..(14,15) with tw=0;
  - stage 1 starts (0,2),(1,3),(4,6) with tw 0,4,0;
  - stage 3 is (0,8)..(7,15) with tw 0..7;
  - done pulses exactly 1 cycle after the (7,15) transfer.
- Backpressure: pair_ready pattern 1,0,0,1 repeating -> outputs held stable through stall cycles; same 32-pair sequence; no pair dropped or duplicated.
- start held high through a whole transform -> a second transform begins only after DONE→IDLE; busy low for at least 1 cycle between the two.
- rst asserted during stage 2 -> all outputs 0 asynchronously; no done; a fresh start restarts at stage 0 with pair (0,1).
- SAMPLES=4 -> 4 pairs: (0,1),(2,3),(0,2),(1,3) with tw 0,0,0,1; last_pair only on (1,3).
- FFT_SEQ_STAGE_BARRIER_EN defined, pipe_idle held low 5 cycles after each stage -> pair_valid=0 for those cycles; stage increments only after pipe_idle=1; done only after the final pipe_idle=1.
